cic_filter: RTL and testbench



---
 rtl/cic_filter.sv | 71 +++++++
 tb/tb_cic_filter.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/cic_filter.sv
// Third-order CIC decimator (R=64) turning a 1-bit PDM stream into unsigned PCM.
// Optional build macro CIC_OUT_VALID_EN adds a one-clock out_valid pulse per update.
module cic_filter #(
    parameter int DEC_RATIO = 64,
    parameter int STAGES    = 3,
    parameter int OUT_W     = 19
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in,
`ifdef CIC_OUT_VALID_EN
    output logic             out_valid,
`endif
    output logic [OUT_W-1:0] out
);

    localparam int CW = $clog2(DEC_RATIO);

    logic [OUT_W-1:0] integ [STAGES];
    logic [OUT_W-1:0] dly   [STAGES];
    logic [OUT_W-1:0] comb  [STAGES];
    logic [CW-1:0]    cnt;
    logic             stb;
    logic [OUT_W-1:0] in_ext;

    assign stb    = (cnt == CW'(DEC_RATIO - 1));
    assign in_ext = {{(OUT_W-1){1'b0}}, in};

    // Integrators run at the input rate; modulo wrap is intentional.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < STAGES; k++)
                integ[k] <= '0;
            cnt <= '0;
        end else begin
            integ[0] <= integ[0] + in_ext;
            for (int k = 1; k < STAGES; k++)
                integ[k] <= integ[k] + integ[k-1];
            cnt <= cnt + CW'(1);
        end
    end

    // Combs form a pipeline at the decimated rate: each stage uses the previous stage's old output.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < STAGES; k++) begin
                dly[k]  <= '0;
                comb[k] <= '0;
            end
            out <= '0;
        end else if (stb) begin
            comb[0] <= integ[STAGES-1] - dly[0];
            dly[0]  <= integ[STAGES-1];
            for (int k = 1; k < STAGES; k++) begin
                comb[k] <= comb[k-1] - dly[k];
                dly[k]  <= comb[k-1];
            end
            out <= comb[STAGES-1];
        end
    end

`ifdef CIC_OUT_VALID_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            out_valid <= 1'b0;
        else
            out_valid <= stb;
    end
`endif

endmodule

// File: tb/tb_cic_filter.sv
// Scoreboard bench for cic_filter: a closed-form triple-sum model predicts every update.
module tb_cic_filter;

    localparam int  R     = 64;
    localparam int  W     = 19;
    localparam longint MASK = (longint'(1) << W) - 1;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in = 1'b0;
    logic [W-1:0] out;
`ifdef CIC_OUT_VALID_EN
    logic         out_valid;
`endif

    int n_chk  = 0;
    int n_pass = 0;

    bit     hist[$];
    longint exp_q[$];
    longint last_exp;
    int     t;
    real    sd_acc;

    always #5 clk = ~clk;

    cic_filter #(.DEC_RATIO(R), .STAGES(3), .OUT_W(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in        (in),
`ifdef CIC_OUT_VALID_EN
        .out_valid (out_valid),
`endif
        .out       (out)
    );

    task automatic check_val(input string tag, input longint obs, input longint expv);
        n_chk++;
        if (obs == expv) n_pass++;
        else $display("FAIL %s: got %0d, want %0d (t=%0d)", tag, obs, expv, t);
    endtask

    // Third integrator value after edge n: sum of x_s * C(n-s, 2).
    function automatic longint integ3(input int n);
        longint acc = 0;
        for (int s = 1; s <= n; s++)
            if (hist[s-1]) acc += longint'(n - s) * longint'(n - s - 1) / 2;
        return acc & MASK;
    endfunction

    // Value seen by the combs at decimation edge k (register state before the edge).
    function automatic longint a_at(input int k);
        if (k <= 0) return 0;
        return integ3(R * k - 1);
    endfunction

    function automatic longint model_out(input int m);
        longint v;
        v = a_at(m-3) - 3 * a_at(m-4) + 3 * a_at(m-5) - a_at(m-6);
        return v & MASK;
    endfunction

    function automatic bit pattern(input int mode, input int n);
        real v;
        case (mode)
            0: return 1'b0;
            1: return 1'b1;
            2: return (n % 2) == 1;
            3: return (n % 4) == 1;
            default: begin
                v = 0.5 + 0.4 * $sin(2.0 * 3.14159265358979 * 1000.0 * n / 6.4e6);
                sd_acc += v;
                if (sd_acc >= 1.0) begin
                    sd_acc -= 1.0;
                    return 1'b1;
                end
                return 1'b0;
            end
        endcase
    endfunction

    // Assert reset between edges and hold it ~500 ns with random input; out must stay 0.
    task automatic do_reset();
        #2 rst_n = 1'b0;
        #1 check_val("out_async_rst", out, 0);
        for (int i = 0; i < 50; i++) begin
            @(negedge clk) in = 1'($urandom_range(0, 1));
            @(posedge clk) #1;
            check_val("out_in_rst", out, 0);
`ifdef CIC_OUT_VALID_EN
            check_val("valid_in_rst", out_valid, 0);
`endif
        end
        hist.delete();
        exp_q.delete();
        last_exp = 0;
        t = 0;
        sd_acc = 0.0;
        rst_n = 1'b1;
    endtask

    // Drive n cycles of a pattern; ss >= 0 gives the settled value required from update 8 on.
    task automatic run(input string tag, input int mode, input int n, input longint ss);
        longint e;
        int m;
        for (int i = 0; i < n; i++) begin
            @(negedge clk) in = pattern(mode, t + 1);
            @(posedge clk);
            t++;
            hist.push_back(in);
            if (t % R == 0) exp_q.push_back(model_out(t / R));
            #1;
            if (t % R == 0) begin
                m = t / R;
                e = exp_q.pop_front();
                last_exp = e;
                check_val({tag, "_upd"}, out, e);
                if (ss >= 0 && m >= 8) check_val({tag, "_settled"}, out, ss);
            end else begin
                check_val({tag, "_hold"}, out, last_exp);
            end
`ifdef CIC_OUT_VALID_EN
            check_val({tag, "_valid"}, out_valid, (t % R == 0) ? 1 : 0);
`endif
        end
    endtask

    initial begin
        t = 0;
        last_exp = 0;
        sd_acc = 0.0;
        @(posedge clk) #1;
        do_reset();
        run("zero", 0, 20 * R, 0);

        do_reset();
        run("ones", 1, 12 * R, 262144);

        do_reset();
        run("half", 2, 12 * R, 131072);

        do_reset();
        run("quarter", 3, 12 * R, 65536);

        do_reset();
        run("wrap", 1, 10000, 262144);

        do_reset();
        run("sine", 4, 2000, -1);
        check_val("sine_nonzero", (out != 0) ? 1 : 0, 1);
        do_reset();
        run("sine_restart", 4, 10 * R, -1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL timeout: got no finish, want finish within 5 ms");
        $fatal(1, "timeout");
    end

endmodule
